keypad_calc_seq: RTL
====================

// Module: keypad_calc_seq
// PURPOSE
//  Keypad-driven multi-cycle integer calculator; parametrised successor of the 2-digit calculator.
//  Captures two DIGITS-digit decimal operands from a 4-bit keypad code and applies ADD/SUB/MUL/DIV.
//  MUL/DIV use iterative datapaths; a sequential double-dabble stage converts the result to BCD.
//  Output BCD feeds the existing 7-segment display driver, which is external to this block.
// PARAMETERS
//  DIGITS      2   decimal digits per operand (1..4)
//  AW          7   operand binary width; must hold 10^DIGITS-1
//  RES_DIGITS  4   BCD result digits on disp_bcd; must be >= DIGITS
//  RW = 2*AW is a localparam: result binary width.
// PORTS
//  clk       in   1              clock
//  rst       in   1              synchronous, active-high reset
//  key       in   4              keypad code: 0 none, 1-9 digit, 10 digit 0, 11 ADD, 12 SUB, 13 MUL, 14 DIV, 15 ENTER
//  disp_bcd  out  4*RES_DIGITS   BCD digits, LS digit in [3:0]
//  neg       out  1              result negative (SUB only)
//  err       out  1              divide-by-zero or overflow
//  busy      out  1              CALC or CONV in progress
//  rem_bcd   out  4*DIGITS       DIV remainder in BCD (see CONFIGURATION)
//  state     out  3              FSM state, for debug
// BEHAVIOUR
//  - Reset: state=ENTRY_A; A=B=0; op=ADD; disp_bcd=0; rem_bcd=0; neg=0; err=0; busy=0.
//  - prev_key<=key every cycle, including while busy. Press = key!=0 && key!=prev_key.
//    A held key counts once. Releasing to 0 re-arms the same key.
//  - ENTRY_A (0): a digit press does A<=A*10+d, unless DIGITS digits are already in; extra digits are ignored.
//    An op press latches op and goes to ENTRY_B. ENTER is ignored here.
//  - ENTRY_B (1): digits load B the same way. An op press replaces op, with B unchanged.
//    ENTER goes to CALC and busy goes high the next cycle.
//  - CALC (2): ADD/SUB take 1 cycle. SUB with A<B gives res=B-A and neg=1.
//    MUL is shift-add, AW cycles. DIV is restoring division, AW cycles, giving quotient and remainder.
//    DIV with B==0 takes 1 cycle, sets err=1, then goes straight to DONE.
//  - CONV (3): double dabble, exactly RW cycles. If res > 10^RES_DIGITS-1, set err=1.
//  - DONE (4): busy=0. If err, every disp_bcd digit is 4'hE; otherwise disp_bcd = BCD(res).
//    ENTER clears A, B, neg, err, disp_bcd, rem_bcd and goes to ENTRY_A. All other keys are ignored.
//  - Latency from the ENTER sample edge to DONE: ADD/SUB 1+RW cycles; MUL/DIV AW+RW cycles (21 at defaults).
//  - Display contents: disp_bcd shows A right-aligned in ENTRY_A and B right-aligned in ENTRY_B.
//    It is held constant during CALC and CONV.
//  - Key presses while busy are dropped. They are not queued.
//  - rst mid-CALC or mid-CONV aborts to the reset state in 1 cycle. No partial result is shown.
//  - States 5-7 are illegal; the FSM recovers to ENTRY_A on the next cycle.
// CONFIGURATION
//  CALC_REM_EN defined: in DONE after a DIV, rem_bcd = BCD(A mod B). It is 0 after any other op or after err.
//  CALC_REM_EN undefined: rem_bcd is tied to 0, and the remainder register and its BCD logic are not built.
//    Quotient behaviour is identical in both builds.
// TESTING  (DIGITS=2, AW=7, RES_DIGITS=4)
//  1 keys 1,2,ADD,3,4,ENTER -> busy for 15 cycles; disp_bcd=16'h0046, neg=0, err=0.
//  2 keys 7,SUB,2,10,ENTER -> disp_bcd=16'h0013, neg=1.
//  3 keys 9,9,MUL,9,9,ENTER -> DONE exactly 21 cycles after ENTER; disp_bcd=16'h9801.
//  4 keys 4,7,DIV,5,ENTER -> disp_bcd=16'h0009; rem_bcd=8'h02 with CALC_REM_EN, 8'h00 without.
//  5 keys 5,DIV,10,ENTER -> err=1, disp_bcd=16'hEEEE; a later ENTER -> ENTRY_A, all outputs 0.
//  6 Key 3 held 5 cycles, then 3,4,5 with 0 between each -> A=34 (third digit ignored).
//    rst pulsed during CALC -> reset values next cycle.

Source files
------------

// File: rtl/keypad_calc_seq.sv
// rtl/keypad_calc_seq.sv - keypad calculator with iterative MUL/DIV and double-dabble BCD output
// Optional feature macro: CALC_REM_EN (BCD remainder on rem_bcd after DIV).
module keypad_calc_seq #(
    parameter int DIGITS     = 2,
    parameter int AW         = 7,
    parameter int RES_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key,
    output logic [4*RES_DIGITS-1:0] disp_bcd,
    output logic                    neg,
    output logic                    err,
    output logic                    busy,
    output logic [4*DIGITS-1:0]     rem_bcd,
    output logic [2:0]              state
);
    localparam int RW      = 2 * AW;
    localparam int RES_MAX = 10**RES_DIGITS - 1;

    typedef enum logic [2:0] {
        S_ENTRY_A = 3'd0,
        S_ENTRY_B = 3'd1,
        S_CALC    = 3'd2,
        S_CONV    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t                  r_state;
    op_t                     r_op;
    logic [3:0]              r_prev_key;
    logic [AW-1:0]           r_a, r_b;
    logic [2:0]              r_ndig;
    logic [5:0]              r_cnt;
    logic [RW-1:0]           r_res, r_mcand, r_sh;
    logic [AW-1:0]           r_mplier, r_quo, r_rem;
    logic [4*RES_DIGITS-1:0] r_bcd, r_disp;
    logic                    r_neg, r_err, r_busy;

    logic                    w_press, w_is_digit, w_is_op, w_is_enter, w_room;
    logic [3:0]              w_digit;
    op_t                     w_op;
    logic [AW-1:0]           w_a_next, w_b_next;
    logic [4*RES_DIGITS-1:0] w_disp_shift;
    logic [AW:0]             w_div_shift;
    logic                    w_div_ge;
    logic [AW-1:0]           w_div_diff, w_rem_next, w_quo_next;
    logic [RW-1:0]           w_mul_next, w_calc_res;
    logic                    w_calc_last, w_a_lt_b, w_div_zero, w_ovf;
    logic [4*RES_DIGITS-1:0] w_bcd_adj, w_bcd_next;

    // A key counts once per transition away from the previously sampled code.
    assign w_press      = (key != 4'd0) && (key != r_prev_key);
    assign w_is_digit   = w_press && (key <= 4'd10);
    assign w_is_op      = w_press && (key >= 4'd11) && (key <= 4'd14);
    assign w_is_enter   = w_press && (key == 4'd15);
    assign w_digit      = (key == 4'd10) ? 4'd0 : key;
    assign w_op         = op_t'(key[1:0] + 2'd1);
    assign w_room       = r_ndig < 3'(DIGITS);
    assign w_a_next     = r_a * AW'(10) + AW'(w_digit);
    assign w_b_next     = r_b * AW'(10) + AW'(w_digit);
    assign w_disp_shift = (r_disp << 4) | (4*RES_DIGITS)'(w_digit);

    // Restoring division: quotient shifts out of r_quo into the partial remainder.
    assign w_div_shift  = {r_rem, r_quo[AW-1]};
    assign w_div_ge     = w_div_shift >= {1'b0, r_b};
    assign w_div_diff   = w_div_shift[AW-1:0] - r_b;
    assign w_rem_next   = w_div_ge ? w_div_diff : w_div_shift[AW-1:0];
    assign w_quo_next   = {r_quo[AW-2:0], w_div_ge};
    assign w_mul_next   = r_res + (r_mplier[0] ? r_mcand : '0);
    assign w_a_lt_b     = r_a < r_b;
    assign w_div_zero   = (r_op == OP_DIV) && (r_b == '0);
    assign w_ovf        = 32'(r_res) > 32'(RES_MAX);

    always_comb begin
        w_calc_res  = '0;
        w_calc_last = 1'b1;
        case (r_op)
            OP_ADD: w_calc_res = RW'(r_a) + RW'(r_b);
            OP_SUB: w_calc_res = w_a_lt_b ? (RW'(r_b) - RW'(r_a)) : (RW'(r_a) - RW'(r_b));
            OP_MUL: begin
                w_calc_res  = w_mul_next;
                w_calc_last = (r_cnt == 6'(AW-1));
            end
            default: begin
                w_calc_res  = RW'(w_quo_next);
                w_calc_last = (r_cnt == 6'(AW-1));
            end
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < RES_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end
    assign w_bcd_next = {w_bcd_adj[4*RES_DIGITS-2:0], r_sh[RW-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ENTRY_A;
            r_op       <= OP_ADD;
            r_prev_key <= 4'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_ndig     <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_sh       <= '0;
            r_bcd      <= '0;
            r_disp     <= '0;
            r_neg      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_prev_key <= key;
            case (r_state)
                S_ENTRY_A: begin
                    if (w_is_digit) begin
                        if (w_room) begin
                            r_a    <= w_a_next;
                            r_ndig <= r_ndig + 3'd1;
                            r_disp <= w_disp_shift;
                        end
                    end else if (w_is_op) begin
                        r_op    <= w_op;
                        r_ndig  <= '0;
                        r_disp  <= '0;
                        r_state <= S_ENTRY_B;
                    end
                end
                S_ENTRY_B: begin
                    if (w_is_digit) begin
                        if (w_room) begin
                            r_b    <= w_b_next;
                            r_ndig <= r_ndig + 3'd1;
                            r_disp <= w_disp_shift;
                        end
                    end else if (w_is_op) begin
                        r_op <= w_op;
                    end else if (w_is_enter) begin
                        r_cnt    <= '0;
                        r_res    <= '0;
                        r_mcand  <= RW'(r_a);
                        r_mplier <= r_b;
                        r_quo    <= r_a;
                        r_rem    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_div_zero) begin
                        r_err   <= 1'b1;
                        r_disp  <= {RES_DIGITS{4'hE}};
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt    <= r_cnt + 6'd1;
                        r_res    <= w_calc_res;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_quo    <= w_quo_next;
                        r_rem    <= w_rem_next;
                        if (w_calc_last) begin
                            r_cnt   <= '0;
                            r_sh    <= w_calc_res;
                            r_bcd   <= '0;
                            r_neg   <= (r_op == OP_SUB) && w_a_lt_b;
                            r_state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_sh  <= r_sh << 1;
                    r_bcd <= w_bcd_next;
                    if (r_cnt == 6'(RW-1)) begin
                        r_err   <= w_ovf;
                        r_disp  <= w_ovf ? {RES_DIGITS{4'hE}} : w_bcd_next;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_is_enter) begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_ndig  <= '0;
                        r_neg   <= 1'b0;
                        r_err   <= 1'b0;
                        r_disp  <= '0;
                        r_state <= S_ENTRY_A;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_ENTRY_A;
                end
            endcase
        end
    end

`ifdef CALC_REM_EN
    logic [RW-1:0]       r_rsh;
    logic [4*DIGITS-1:0] r_rbcd, r_rem_out;
    logic [4*DIGITS-1:0] w_rbcd_adj, w_rbcd_next;

    always_comb begin
        w_rbcd_adj = r_rbcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_rbcd[4*i +: 4] >= 4'd5)
                w_rbcd_adj[4*i +: 4] = r_rbcd[4*i +: 4] + 4'd3;
        end
    end
    assign w_rbcd_next = {w_rbcd_adj[4*DIGITS-2:0], r_rsh[RW-1]};

    // Remainder converts alongside the quotient; its leading zeros shift through harmlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsh     <= '0;
            r_rbcd    <= '0;
            r_rem_out <= '0;
        end else begin
            case (r_state)
                S_CALC: begin
                    if (w_calc_last) begin
                        r_rsh  <= RW'(w_rem_next);
                        r_rbcd <= '0;
                    end
                end
                S_CONV: begin
                    r_rsh  <= r_rsh << 1;
                    r_rbcd <= w_rbcd_next;
                    if (r_cnt == 6'(RW-1))
                        r_rem_out <= ((r_op == OP_DIV) && !w_ovf) ? w_rbcd_next : '0;
                end
                S_DONE: begin
                    if (w_is_enter)
                        r_rem_out <= '0;
                end
                default: ;
            endcase
        end
    end
    assign rem_bcd = r_rem_out;
`else
    assign rem_bcd = '0;
`endif

    assign disp_bcd = r_disp;
    assign neg      = r_neg;
    assign err      = r_err;
    assign busy     = r_busy;
    assign state    = r_state;
endmodule
